// File: rtl/core_control_debug_seq_pkg.sv
// rtl/core_control_debug_seq_pkg.sv - debug sequencer types and defaults
package core_control_debug_seq_pkg;

  localparam int DBG_STEP_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_REQ  = 2'd1,
    CAUSE_STEP = 2'd2,
    CAUSE_BKPT = 2'd3
  } dbg_cause_t;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_HALTED    = 3'd2,
    ST_STEP      = 3'd3,
    ST_STEP_WAIT = 3'd4
  } dbg_state_t;

endpackage

// File: rtl/core_control_debug_step_ctr.sv
// rtl/core_control_debug_step_ctr.sv - loadable saturating counter with terminal flag
module core_control_debug_step_ctr #(
  parameter int W  = 8,
  parameter bit UP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  // Terminal value: zero when counting down, all-ones when counting up.
  localparam logic [W-1:0] LIMIT = UP ? {W{1'b1}} : {W{1'b0}};

  assign term = (cnt == LIMIT);

  // Load has priority over counting; counting stops at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !term) begin
      cnt <= UP ? (cnt + W'(1)) : (cnt - W'(1));
    end
  end

endmodule

// File: rtl/core_control_debug_seq.sv
// rtl/core_control_debug_seq.sv - debug halt/resume/single-step sequencer
module core_control_debug_seq
  import core_control_debug_seq_pkg::*;
#(
  parameter int STEP_W       = DBG_STEP_W_DEFAULT,
  parameter int HALT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_halt_req,
  input  logic              dbg_resume_req,
  input  logic              dbg_step_req,
  input  logic [STEP_W-1:0] dbg_step_count,
  input  logic              bkpt_hit,
  input  logic              halted,
  input  logic              insn_issued,
  output logic              halt,
  output logic              dbg_ack,
  output logic              dbg_halted,
  output logic [1:0]        dbg_cause,
  output logic              dbg_timeout
);

  localparam int TMO_W = $clog2(HALT_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TIMEOUT - 1);

  dbg_state_t        state;
  dbg_cause_t        cause;
  logic              timeout_r;
  logic              ack_q;

  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_load_val;
  logic              step_load;
  logic              step_en;
  logic              step_zero;

  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_load;
  logic              tmo_en;
  logic              tmo_sat;

  logic              in_wait;
  logic              wait_done;
  logic              resume_take;
  logic              step_take;

  assign in_wait   = (state == ST_HALT_WAIT) || (state == ST_STEP_WAIT);
  assign wait_done = in_wait && halted;

  // Requests landing in the cycle right after an ack are dropped so that
  // dbg_ack can never be high two cycles in a row. Resume beats step.
  assign resume_take = (state == ST_HALTED) && !ack_q && dbg_resume_req;
  assign step_take   = (state == ST_HALTED) && !ack_q && !dbg_resume_req && dbg_step_req;

  assign dbg_ack     = wait_done || resume_take;
  assign halt        = (state == ST_STEP) ? step_zero : (state != ST_RUN);
  assign dbg_halted  = (state == ST_HALTED);
  assign dbg_cause   = cause;
  assign dbg_timeout = timeout_r;

  // Step counter control: load on step accept, force to zero on halt/bkpt, count issues.
  always_comb begin
    step_load     = 1'b0;
    step_load_val = '0;
    step_en       = 1'b0;
    if (step_take) begin
      step_load     = 1'b1;
      step_load_val = (dbg_step_count == '0) ? STEP_W'(1) : dbg_step_count;
    end else if ((state == ST_STEP) && !step_zero) begin
      if (dbg_halt_req || bkpt_hit) begin
        step_load = 1'b1;
      end else begin
        step_en = insn_issued;
      end
    end
  end

  // Timeout counter clears on entry to either wait state and counts while waiting.
  always_comb begin
    tmo_load = ((state == ST_RUN) && (dbg_halt_req || bkpt_hit)) ||
               ((state == ST_STEP) && step_zero);
    tmo_en   = in_wait && !tmo_sat;
  end

  core_control_debug_step_ctr #(
    .W  (STEP_W),
    .UP (1'b0)
  ) u_step_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (step_load),
    .load_val (step_load_val),
    .en       (step_en),
    .cnt      (step_cnt),
    .term     (step_zero)
  );

  core_control_debug_step_ctr #(
    .W  (TMO_W),
    .UP (1'b1)
  ) u_tmo_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val ({TMO_W{1'b0}}),
    .en       (tmo_en),
    .cnt      (tmo_cnt),
    .term     (tmo_sat)
  );

  // Sequencer FSM: state, halt cause and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      cause     <= CAUSE_NONE;
      timeout_r <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= dbg_ack;
      case (state)
        ST_RUN: begin
          if (dbg_halt_req) begin
            state <= ST_HALT_WAIT;
            cause <= CAUSE_REQ;
          end else if (bkpt_hit) begin
            state <= ST_HALT_WAIT;
            cause <= CAUSE_BKPT;
          end
        end
        ST_HALT_WAIT, ST_STEP_WAIT: begin
          if (halted) begin
            state <= ST_HALTED;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_r <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (resume_take) begin
            state     <= ST_RUN;
            cause     <= CAUSE_NONE;
            timeout_r <= 1'b0;
          end else if (step_take) begin
            state <= ST_STEP;
            cause <= CAUSE_STEP;
          end
        end
        ST_STEP: begin
          if (step_zero) begin
            state <= ST_STEP_WAIT;
          end else if (dbg_halt_req) begin
            cause <= CAUSE_REQ;
          end else if (bkpt_hit) begin
            cause <= CAUSE_BKPT;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_control_debug_seq.sv
// tb/tb_core_control_debug_seq.sv - self-checking bench for the debug sequencer
module tb_core_control_debug_seq;

  localparam int STEP_W = 8;
  localparam int HT     = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              dbg_halt_req, dbg_resume_req, dbg_step_req;
  logic [STEP_W-1:0] dbg_step_count;
  logic              bkpt_hit, halted, insn_issued;
  logic              halt, dbg_ack, dbg_halted, dbg_timeout;
  logic [1:0]        dbg_cause;

  int n_cmp = 0;
  int n_bad = 0;

  // expected/actual packing: {halt, ack, dbg_halted, cause[1:0], timeout}
  typedef struct {
    logic       hr, rr, sr;
    logic [7:0] cnt;
    logic       bk, hd, is;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  core_control_debug_seq #(
    .STEP_W       (STEP_W),
    .HALT_TIMEOUT (HT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume_req (dbg_resume_req),
    .dbg_step_req   (dbg_step_req),
    .dbg_step_count (dbg_step_count),
    .bkpt_hit       (bkpt_hit),
    .halted         (halted),
    .insn_issued    (insn_issued),
    .halt           (halt),
    .dbg_ack        (dbg_ack),
    .dbg_halted     (dbg_halted),
    .dbg_cause      (dbg_cause),
    .dbg_timeout    (dbg_timeout)
  );

  function automatic vec_t mk(logic hr, logic rr, logic sr, logic [7:0] cnt,
                              logic bk, logic hd, logic is, logic [5:0] exp);
    vec_t v;
    v.hr = hr; v.rr = rr; v.sr = sr; v.cnt = cnt;
    v.bk = bk; v.hd = hd; v.is = is; v.exp = exp;
    return v;
  endfunction

  task automatic drive(logic hr, logic rr, logic sr, logic [7:0] cnt,
                       logic bk, logic hd, logic is);
    dbg_halt_req   = hr;
    dbg_resume_req = rr;
    dbg_step_req   = sr;
    dbg_step_count = cnt;
    bkpt_hit       = bk;
    halted         = hd;
    insn_issued    = is;
  endtask

  task automatic chk(string name, logic [5:0] exp);
    logic [5:0] act;
    act = {halt, dbg_ack, dbg_halted, dbg_cause, dbg_timeout};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {halt,ack,halted,cause,tmo}=%b expected %b", name, $time, act, exp);
    end
  endtask

  // One cycle: apply inputs just after the edge, check mid-cycle, advance.
  task automatic cyc(string name, logic hr, logic rr, logic sr, logic [7:0] cnt,
                     logic bk, logic hd, logic is, logic [5:0] exp);
    drive(hr, rr, sr, cnt, bk, hd, is);
    #2;
    chk(name, exp);
    @(posedge clk);
    #1;
  endtask

  // Reference model state, described in terms of the debug protocol
  localparam int M_RUN = 0, M_WAIT = 1, M_HALTED = 2, M_STEP = 3;
  int   m_mode, m_left, m_waited, m_cause;
  bit   m_tmo, m_prev_ack;

  initial begin
    logic       hr, rr, sr, bk, hd, is;
    logic [7:0] cnt;
    bit         e_halt, e_ack;

    rst = 1'b1;
    drive(0, 0, 0, 8'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 6'b000000);
    rst = 1'b0;

    //            hr rr sr cnt    bk hd is   h a d cc t
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b0_0_0_00_0)); //  0 RUN idle
    tbl.push_back(mk(1, 0, 0, 8'd0,  0, 0, 0, 6'b0_0_0_00_0)); //  1 halt req
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_0_01_0)); //  2 HALT_WAIT
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 0, 6'b1_1_0_01_0)); //  3 halted -> ack
    tbl.push_back(mk(0, 1, 0, 8'd0,  0, 0, 0, 6'b1_0_1_01_0)); //  4 resume right after ack dropped
    tbl.push_back(mk(0, 0, 1, 8'd3,  0, 0, 0, 6'b1_0_1_01_0)); //  5 step 3
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 1, 6'b0_0_0_10_0)); //  6 issue 1
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 1, 6'b0_0_0_10_0)); //  7 issue 2
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b0_0_0_10_0)); //  8 bubble
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 1, 6'b0_0_0_10_0)); //  9 issue 3
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_0_10_0)); // 10 halt after 3rd issue
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_0_10_0)); // 11 STEP_WAIT
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 0, 6'b1_1_0_10_0)); // 12 halted -> ack
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_1_10_0)); // 13 HALTED
    tbl.push_back(mk(0, 0, 1, 8'd0,  0, 0, 0, 6'b1_0_1_10_0)); // 14 step 0 -> 1
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 1, 6'b0_0_0_10_0)); // 15 single issue
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_0_10_0)); // 16 halt
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 0, 6'b1_1_0_10_0)); // 17 ack
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_1_10_0)); // 18 HALTED
    tbl.push_back(mk(0, 0, 1, 8'd10, 0, 0, 0, 6'b1_0_1_10_0)); // 19 step 10
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 1, 6'b0_0_0_10_0)); // 20 issue 1
    tbl.push_back(mk(0, 0, 0, 8'd0,  1, 0, 1, 6'b0_0_0_10_0)); // 21 issue 2 with bkpt
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_0_11_0)); // 22 halted by bkpt
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 0, 6'b1_1_0_11_0)); // 23 ack
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_1_11_0)); // 24 HALTED
    tbl.push_back(mk(0, 1, 1, 8'd4,  0, 0, 0, 6'b1_1_1_11_0)); // 25 resume+step: resume wins
    tbl.push_back(mk(0, 1, 1, 8'd4,  0, 0, 0, 6'b0_0_0_00_0)); // 26 RUN ignores resume/step
    tbl.push_back(mk(0, 0, 0, 8'd0,  1, 0, 0, 6'b0_0_0_00_0)); // 27 bkpt in RUN
    tbl.push_back(mk(1, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_0_11_0)); // 28 HALT_WAIT ignores req
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 0, 6'b1_1_0_11_0)); // 29 ack
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_1_11_0)); // 30 HALTED
    tbl.push_back(mk(0, 0, 1, 8'd5,  0, 0, 0, 6'b1_0_1_11_0)); // 31 step 5
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 1, 6'b0_0_0_10_0)); // 32 issue 1
    tbl.push_back(mk(1, 0, 0, 8'd0,  1, 0, 0, 6'b0_0_0_10_0)); // 33 halt req beats bkpt
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 0, 6'b1_0_0_01_0)); // 34 halted ignored in STEP
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 1, 0, 6'b1_1_0_01_0)); // 35 ack
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_1_01_0)); // 36 HALTED
    tbl.push_back(mk(0, 1, 0, 8'd0,  0, 0, 0, 6'b1_1_1_01_0)); // 37 resume
    tbl.push_back(mk(0, 0, 0, 8'd0,  0, 0, 0, 6'b0_0_0_00_0)); // 38 RUN

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("tbl_row%0d", i), tbl[i].hr, tbl[i].rr, tbl[i].sr, tbl[i].cnt,
          tbl[i].bk, tbl[i].hd, tbl[i].is, tbl[i].exp);
    end

    // Timeout: flag appears HALT_TIMEOUT cycles after entering HALT_WAIT and sticks
    cyc("to_req", 1, 0, 0, 8'd0, 0, 0, 0, 6'b0_0_0_00_0);
    for (int k = 0; k < HT + 5; k++) begin
      cyc("to_wait", 0, 0, 0, 8'd0, 0, 0, 0, {1'b1, 1'b0, 1'b0, 2'd1, (k >= HT)});
    end
    cyc("to_ack",     0, 0, 0, 8'd0, 0, 1, 0, 6'b1_1_0_01_1);
    cyc("to_halted",  0, 0, 0, 8'd0, 0, 0, 0, 6'b1_0_1_01_1);
    cyc("to_resume",  0, 1, 0, 8'd0, 0, 0, 0, 6'b1_1_1_01_1);
    cyc("to_cleared", 0, 0, 0, 8'd0, 0, 0, 0, 6'b0_0_0_00_0);

    // Asynchronous reset in the middle of a step
    cyc("rs_req",    1, 0, 0, 8'd0,  0, 0, 0, 6'b0_0_0_00_0);
    cyc("rs_ack",    0, 0, 0, 8'd0,  0, 1, 0, 6'b1_1_0_01_0);
    cyc("rs_halted", 0, 0, 0, 8'd0,  0, 0, 0, 6'b1_0_1_01_0);
    cyc("rs_step",   0, 0, 1, 8'd50, 0, 0, 0, 6'b1_0_1_01_0);
    cyc("rs_issue",  0, 0, 0, 8'd0,  0, 0, 1, 6'b0_0_0_10_0);
    cyc("rs_bkpt",   0, 0, 0, 8'd0,  1, 0, 1, 6'b0_0_0_10_0);
    drive(0, 0, 0, 8'd0, 0, 0, 0);
    #2;
    chk("rs_pre", 6'b1_0_0_11_0);
    rst = 1'b1;
    #1;
    chk("rs_async", 6'b0_0_0_00_0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("rs_run",  0, 0, 0, 8'd0, 1, 0, 0, 6'b0_0_0_00_0);
    cyc("rs_post", 0, 0, 0, 8'd0, 0, 0, 0, 6'b1_0_0_11_0);

    // Randomized traffic against the protocol-level model
    rst = 1'b1;
    drive(0, 0, 0, 8'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = M_RUN; m_left = 0; m_waited = 0; m_cause = 0; m_tmo = 0; m_prev_ack = 0;
    for (int c = 0; c < 3000; c++) begin
      hr  = ($urandom_range(0, 19) == 0);
      rr  = ($urandom_range(0, 5) == 0);
      sr  = ($urandom_range(0, 4) == 0);
      cnt = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      bk  = ($urandom_range(0, 29) == 0);
      hd  = ($urandom_range(0, 3) == 0);

      // The core may only issue while it is not held
      e_halt = (m_mode == M_RUN) ? 1'b0 : (m_mode == M_STEP) ? (m_left == 0) : 1'b1;
      is     = !e_halt && ($urandom_range(0, 1) == 1);
      e_ack  = ((m_mode == M_WAIT) && hd) ||
               ((m_mode == M_HALTED) && rr && !m_prev_ack);

      drive(hr, rr, sr, cnt, bk, hd, is);
      #2;
      chk("random", {e_halt, e_ack, (m_mode == M_HALTED), 2'(m_cause), m_tmo});

      case (m_mode)
        M_RUN: begin
          if (hr)      begin m_mode = M_WAIT; m_cause = 1; m_waited = 0; end
          else if (bk) begin m_mode = M_WAIT; m_cause = 3; m_waited = 0; end
        end
        M_WAIT: begin
          if (hd) m_mode = M_HALTED;
          else begin
            if (m_waited == HT - 1) m_tmo = 1;
            m_waited++;
          end
        end
        M_HALTED: begin
          if (!m_prev_ack && rr) begin
            m_mode = M_RUN; m_cause = 0; m_tmo = 0;
          end else if (!m_prev_ack && sr) begin
            m_mode = M_STEP; m_cause = 2;
            m_left = (cnt == 0) ? 1 : int'(cnt);
          end
        end
        default: begin
          if (m_left == 0)  begin m_mode = M_WAIT; m_waited = 0; end
          else if (hr)      begin m_left = 0; m_cause = 1; end
          else if (bk)      begin m_left = 0; m_cause = 3; end
          else if (is)      m_left--;
        end
      endcase
      m_prev_ack = e_ack;

      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_control_debug_seq.md
Name: core_control_debug_seq

Overview:
- Debug halt/step sequencer for the core. Drives the `halt` input of the core stall/hazard unit and turns debug-port requests into clean halt, resume and N-instruction single-step sequences.
- Tracks halt cause and reports completion to the debug port with a one-cycle ack pulse.
- Sits between the debug bus front-end and core control.

Parameters:
- STEP_W, 8, width of the step-count field; max step = 2^STEP_W-1.
- HALT_TIMEOUT, 1024, cycles to wait in HALT_WAIT for `halted` before flagging error.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- dbg_halt_req  input  1  one-cycle pulse: request halt
- dbg_resume_req  input  1  one-cycle pulse: resume free-running
- dbg_step_req  input  1  one-cycle pulse: execute dbg_step_count instructions, then halt
- dbg_step_count  input  STEP_W  instruction count; sampled with dbg_step_req; 0 treated as 1
- bkpt_hit  input  1  breakpoint match on instruction at issue
- halted  input  1  from stall unit: core quiesced under halt
- insn_issued  input  1  an instruction left issue this cycle (issue && !stall)
- halt  output  1  to stall unit
- dbg_ack  output  1  one-cycle pulse on halt/step completion or resume accept
- dbg_halted  output  1  core is in HALTED state
- dbg_cause  output  2  dbg_cause_t: NONE=0, REQ=1, STEP=2, BKPT=3
- dbg_timeout  output  1  sticky: HALT_WAIT exceeded HALT_TIMEOUT

Behaviour:
- Reset values: state RUN, halt=0, dbg_ack=0, dbg_halted=0, dbg_cause=NONE, dbg_timeout=0, step counter 0, timeout counter 0. Reset mid-sequence aborts the sequence and returns to RUN.
- States: RUN, HALT_WAIT, HALTED, STEP, STEP_WAIT.
- RUN: halt=0.
  - dbg_halt_req -> HALT_WAIT, cause REQ.
  - else bkpt_hit -> HALT_WAIT, cause BKPT.
  - resume_req and step_req are ignored; no ack.
- HALT_WAIT: halt=1; timeout counter increments each cycle.
  - halted=1 -> HALTED, dbg_ack pulse in the transition cycle.
  - Counter reaches HALT_TIMEOUT-1 -> set dbg_timeout; remain in HALT_WAIT.
  - Requests are ignored.
- HALTED: halt=1, dbg_halted=1.
  - dbg_resume_req -> RUN; dbg_ack pulse; cause NONE; dbg_timeout cleared.
  - dbg_step_req -> STEP; counter loaded with max(dbg_step_count,1).
  - Resume wins if both requests arrive in the same cycle.
- STEP: halt = (counter==0); halt is combinational from the registered counter.
  - insn_issued decrements the counter; it never wraps below 0.
  - Exactly N issues occur: after the Nth issue the counter is 0 next cycle, so halt rises the cycle after the last issue.
  - counter==0 -> STEP_WAIT, cause STEP.
  - dbg_halt_req in STEP forces counter to 0 and sets cause REQ.
  - bkpt_hit in STEP forces counter to 0 and sets cause BKPT.
  - Priority: halt_req > bkpt_hit > normal decrement.
- STEP_WAIT: identical to HALT_WAIT, including timeout handling; on halted=1 -> HALTED with ack.
- Timeout counter: clears on entry to HALT_WAIT/STEP_WAIT; saturates.
- `halted` input is don't-care outside the *_WAIT and HALTED states.
- dbg_ack is never high for two consecutive cycles.

Decomposition:
- Shared core uarch package gains:
  - dbg_cause_t (2-bit enum NONE/REQ/STEP/BKPT)
  - dbg_state_t enum
  - constant for the default step width
- One sub-module: core_control_debug_step_ctr. Loadable, saturating down-counter with a zero flag; reused for the timeout counter with an up/saturate mode parameter.
- FSM stays in the top module.

Test Plan:
- Halt: assert rst, release; halt_req pulse at cycle 5; halted rises cycle 9 -> halt=1 from cycle 6; dbg_ack exactly at cycle 9; dbg_halted=1 from cycle 10; cause=REQ.
- Step 3: from HALTED, step_req with count=3; insn_issued high on cycles 1,2,4 after entry -> halt low until the cycle after the third issue; no fourth issue accepted; HALTED+ack once halted; cause=STEP.
- Step 0 treated as 1: step_req with count=0 -> exactly one issue, then halt.
- Breakpoint during step: count=10, bkpt_hit on the 2nd issue -> halt next cycle; cause=BKPT; total issues=2.
- Timeout: halt_req; hold halted=0 for HALT_TIMEOUT+5 cycles -> dbg_timeout set at cycle HALT_TIMEOUT and sticky; later halted=1 -> HALTED; resume clears timeout, halt=0.
- Simultaneous events and reset: in HALTED, resume_req+step_req same cycle -> RUN, ack. Assert rst mid-STEP -> all outputs at reset values immediately (async), RUN after release.
